// File: rtl/fadd_far_sched.sv
`default_nettype none
// ============================================================================
// Module   : fadd_far_sched
// Function : Two-requester scheduler and issue/output stages for the shared
//            far-path FP adder. Define FADD_FAR_SCHED_FIXED_PRIO_EN for fixed
//            priority (requester 0 always wins) instead of round-robin.
// Revision : 1.0
// ============================================================================
module fadd_far_sched #(
    parameter int FRAC_WIDTH = 40,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [2*FRAC_WIDTH-1:0]   req_a_frac,
    input  logic [2*FRAC_WIDTH-1:0]   req_b_frac,
    input  logic [2*EXP_WIDTH-1:0]    req_a_exp,
    input  logic [2*EXP_WIDTH-1:0]    req_b_exp,
    input  logic [1:0]                req_a_sign,
    input  logic [1:0]                req_b_sign,
    output logic [FRAC_WIDTH-1:0]     dp_esmall_op,
    output logic [FRAC_WIDTH-1:0]     dp_elarge_op,
    output logic [EXP_WIDTH-1:0]      dp_exp_f,
    output logic [EXP_WIDTH:0]        dp_diff_abs,
    output logic                      dp_sign_diff,
    input  logic [FRAC_WIDTH-1:0]     dp_far_result,
    input  logic [EXP_WIDTH-1:0]      dp_exp_far,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAC_WIDTH-1:0]     out_frac,
    output logic [EXP_WIDTH-1:0]      out_exp,
    output logic                      out_sign,
    output logic                      out_id
);

    logic                  w_s2_free;
    logic                  w_s1_free;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_id;
    logic [FRAC_WIDTH-1:0] w_a_frac;
    logic [FRAC_WIDTH-1:0] w_b_frac;
    logic [EXP_WIDTH-1:0]  w_a_exp;
    logic [EXP_WIDTH-1:0]  w_b_exp;
    logic                  w_a_sign;
    logic                  w_b_sign;
    logic                  w_a_large;
    logic [EXP_WIDTH-1:0]  w_exp_l;
    logic [EXP_WIDTH-1:0]  w_exp_s;

    logic                  r_s1_valid;
    logic [FRAC_WIDTH-1:0] r_s1_large;
    logic [FRAC_WIDTH-1:0] r_s1_small;
    logic [EXP_WIDTH-1:0]  r_s1_exp;
    logic [EXP_WIDTH:0]    r_s1_diff;
    logic                  r_s1_sdiff;
    logic                  r_s1_sign;
    logic                  r_s1_id;

    logic                  r_out_valid;
    logic [FRAC_WIDTH-1:0] r_out_frac;
    logic [EXP_WIDTH-1:0]  r_out_exp;
    logic                  r_out_sign;
    logic                  r_out_id;

    assign w_s2_free = ~r_out_valid | out_ready;
    assign w_s1_free = ~r_s1_valid | w_s2_free;

`ifdef FADD_FAR_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_grant = req_valid;
        if (&req_valid) begin
            w_grant = 2'b01;
        end
    end
`else
    logic r_rr_last;

    // Contention goes to the requester that was not served last.
    always_comb begin
        w_grant = req_valid;
        if (&req_valid) begin
            w_grant = r_rr_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_rr_last <= w_id;
        end
    end
`endif

    assign req_ready = w_grant & {2{w_s1_free & rst_n}};
    assign w_accept  = |req_ready;
    assign w_id      = w_grant[1];

    assign w_a_frac  = w_id ? req_a_frac[2*FRAC_WIDTH-1:FRAC_WIDTH] : req_a_frac[FRAC_WIDTH-1:0];
    assign w_b_frac  = w_id ? req_b_frac[2*FRAC_WIDTH-1:FRAC_WIDTH] : req_b_frac[FRAC_WIDTH-1:0];
    assign w_a_exp   = w_id ? req_a_exp[2*EXP_WIDTH-1:EXP_WIDTH]    : req_a_exp[EXP_WIDTH-1:0];
    assign w_b_exp   = w_id ? req_b_exp[2*EXP_WIDTH-1:EXP_WIDTH]    : req_b_exp[EXP_WIDTH-1:0];
    assign w_a_sign  = req_a_sign[w_id];
    assign w_b_sign  = req_b_sign[w_id];

    // Equal magnitudes keep a as the large operand.
    assign w_a_large = (w_a_exp > w_b_exp) ||
                       ((w_a_exp == w_b_exp) && (w_a_frac >= w_b_frac));
    assign w_exp_l   = w_a_large ? w_a_exp : w_b_exp;
    assign w_exp_s   = w_a_large ? w_b_exp : w_a_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_large <= '0;
            r_s1_small <= '0;
            r_s1_exp   <= '0;
            r_s1_diff  <= '0;
            r_s1_sdiff <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_id    <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_large <= w_a_large ? w_a_frac : w_b_frac;
            r_s1_small <= w_a_large ? w_b_frac : w_a_frac;
            r_s1_exp   <= w_exp_l;
            r_s1_diff  <= {1'b0, w_exp_l} - {1'b0, w_exp_s};
            r_s1_sdiff <= w_a_sign ^ w_b_sign;
            r_s1_sign  <= w_a_large ? w_a_sign : w_b_sign;
            r_s1_id    <= w_id;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_frac  <= '0;
            r_out_exp   <= '0;
            r_out_sign  <= 1'b0;
            r_out_id    <= 1'b0;
        end else if (r_s1_valid && w_s2_free) begin
            r_out_valid <= 1'b1;
            r_out_frac  <= dp_far_result;
            r_out_exp   <= dp_exp_far;
            r_out_sign  <= r_s1_sign;
            r_out_id    <= r_s1_id;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign dp_elarge_op = r_s1_large;
    assign dp_esmall_op = r_s1_small;
    assign dp_exp_f     = r_s1_exp;
    assign dp_diff_abs  = r_s1_diff;
    assign dp_sign_diff = r_s1_sdiff;

    assign out_valid    = r_out_valid;
    assign out_frac     = r_out_frac;
    assign out_exp      = r_out_exp;
    assign out_sign     = r_out_sign;
    assign out_id       = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_fadd_far_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_far_sched
// Function : Self-checking bench for fadd_far_sched with a far-path adder model.
// Revision : 1.0
// ============================================================================
module tb_fadd_far_sched;
    localparam int FW = 40;
    localparam int EW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*FW-1:0] req_a_frac, req_b_frac;
    logic [2*EW-1:0] req_a_exp, req_b_exp;
    logic [1:0]      req_a_sign, req_b_sign;
    logic [FW-1:0]   dp_esmall_op, dp_elarge_op, dp_far_result;
    logic [EW-1:0]   dp_exp_f, dp_exp_far;
    logic [EW:0]     dp_diff_abs;
    logic            dp_sign_diff;
    logic            out_valid, out_ready, out_sign, out_id;
    logic [FW-1:0]   out_frac;
    logic [EW-1:0]   out_exp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            id;
        logic [FW-1:0] fa, fb;
        logic [EW-1:0] ea, eb;
        logic          sa, sb;
        logic [EW:0]   ediff;
        logic          esd;
        logic [EW-1:0] eexpf;
        logic [FW-1:0] efrac;
        logic [EW-1:0] eexp;
        logic          esign;
    } vec_t;

    vec_t vecs[6];

    fadd_far_sched #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_frac(req_a_frac), .req_b_frac(req_b_frac),
        .req_a_exp(req_a_exp), .req_b_exp(req_b_exp),
        .req_a_sign(req_a_sign), .req_b_sign(req_b_sign),
        .dp_esmall_op(dp_esmall_op), .dp_elarge_op(dp_elarge_op),
        .dp_exp_f(dp_exp_f), .dp_diff_abs(dp_diff_abs), .dp_sign_diff(dp_sign_diff),
        .dp_far_result(dp_far_result), .dp_exp_far(dp_exp_far),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_frac(out_frac), .out_exp(out_exp), .out_sign(out_sign), .out_id(out_id)
    );

    always #5 clk = ~clk;

    // Far-path adder: align the small operand, add or subtract, normalise one way.
    function automatic logic [EW+FW-1:0] far_add(input logic [FW-1:0] fl, input logic [FW-1:0] fs,
                                                 input logic [EW:0] d, input logic sd,
                                                 input logic [EW-1:0] e);
        logic [FW:0]   s;
        logic [FW-1:0] al;
        logic [EW-1:0] eo;
        al = (d >= 9'(FW)) ? '0 : (fs >> d);
        eo = e;
        if (!sd) begin
            s = {1'b0, fl} + {1'b0, al};
            if (s[FW]) begin
                s  = s >> 1;
                eo = e + 8'd1;
            end
        end else begin
            s = {1'b0, fl} - {1'b0, al};
            for (int k = 0; k < FW; k++) begin
                if (s != 0 && !s[FW-1]) begin
                    s  = s << 1;
                    eo = eo - 8'd1;
                end
            end
        end
        return {eo, s[FW-1:0]};
    endfunction

    always_comb {dp_exp_far, dp_far_result} = far_add(dp_elarge_op, dp_esmall_op,
                                                      dp_diff_abs, dp_sign_diff, dp_exp_f);

    // Reference: whole floating add from raw operands -> {sign, exp, frac}.
    function automatic logic [FW+EW:0] ref_add(input logic [FW-1:0] fa, input logic [EW-1:0] ea,
                                               input logic sa, input logic [FW-1:0] fb,
                                               input logic [EW-1:0] eb, input logic sb);
        logic          a_big;
        logic [EW+FW-1:0] r;
        a_big = {ea, fa} >= {eb, fb};
        if (a_big) r = far_add(fa, fb, 9'(ea) - 9'(eb), sa ^ sb, ea);
        else       r = far_add(fb, fa, 9'(eb) - 9'(ea), sa ^ sb, eb);
        return {a_big ? sa : sb, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [FW-1:0] fa, input logic [EW-1:0] ea,
                           input logic sa, input logic [FW-1:0] fb, input logic [EW-1:0] eb,
                           input logic sb);
        req_a_frac[id*FW +: FW] = fa;
        req_b_frac[id*FW +: FW] = fb;
        req_a_exp[id*EW +: EW]  = ea;
        req_b_exp[id*EW +: EW]  = eb;
        req_a_sign[id]          = sa;
        req_b_sign[id]          = sb;
    endtask

    task automatic set_vec(input int id, input vec_t v);
        set_req(id, v.fa, v.ea, v.sa, v.fb, v.eb, v.sb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    function automatic vec_t mkv(input int id, input logic [FW-1:0] fa, input logic [EW-1:0] ea,
                                 input logic sa, input logic [FW-1:0] fb, input logic [EW-1:0] eb,
                                 input logic sb, input logic [EW:0] ediff, input logic esd,
                                 input logic [EW-1:0] eexpf, input logic [FW-1:0] efrac,
                                 input logic [EW-1:0] eexp, input logic esign);
        vec_t v;
        v.id = id; v.fa = fa; v.ea = ea; v.sa = sa; v.fb = fb; v.eb = eb; v.sb = sb;
        v.ediff = ediff; v.esd = esd; v.eexpf = eexpf;
        v.efrac = efrac; v.eexp = eexp; v.esign = esign;
        return v;
    endfunction

    task automatic rand_ops(input int id);
        logic [FW-1:0] fa, fb;
        logic [EW-1:0] ea, eb;
        int            mode;
        fa   = {1'b1, 7'($urandom), $urandom};
        fb   = {1'b1, 7'($urandom), $urandom};
        ea   = 8'($urandom_range(20, 200));
        mode = $urandom_range(0, 3);
        case (mode)
            0:       begin eb = ea; fb = fa; end
            1:       eb = ea;
            2:       eb = ea + 8'($urandom_range(0, 2));
            default: eb = 8'($urandom_range(20, 200));
        endcase
        set_req(id, fa, ea, 1'($urandom), fb, eb, 1'($urandom));
    endtask

    logic [FW+EW+1:0] q[$];
    logic             m_last;
    logic [1:0]       egrant, erdy;
    logic [FW+EW+1:0] e;
    logic [FW-1:0]    held_frac;
    int               n_out;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
        req_a_frac = '0; req_b_frac = '0; req_a_exp = '0; req_b_exp = '0;
        req_a_sign = '0; req_b_sign = '0;

        vecs[0] = mkv(0, 40'h8000000000, 8'd10, 1'b0, 40'h8000000000, 8'd9,  1'b0,
                      9'd1, 1'b0, 8'd10, 40'hC000000000, 8'd10, 1'b0);
        vecs[1] = mkv(1, 40'h8000000000, 8'd10, 1'b0, 40'h8000000000, 8'd10, 1'b0,
                      9'd0, 1'b0, 8'd10, 40'h8000000000, 8'd11, 1'b0);
        vecs[2] = mkv(0, 40'h8000000000, 8'd9,  1'b0, 40'h8000000000, 8'd10, 1'b1,
                      9'd1, 1'b1, 8'd10, 40'h8000000000, 8'd9,  1'b1);
        vecs[3] = mkv(1, 40'hA000000000, 8'd50, 1'b0, 40'hA000000000, 8'd50, 1'b1,
                      9'd0, 1'b1, 8'd50, 40'h0000000000, 8'd50, 1'b0);
        vecs[4] = mkv(0, 40'h8000000000, 8'd20, 1'b1, 40'hC000000000, 8'd20, 1'b0,
                      9'd0, 1'b1, 8'd20, 40'h8000000000, 8'd19, 1'b0);
        vecs[5] = mkv(1, 40'h8000000000, 8'd100, 1'b0, 40'hFFFFFFFFFF, 8'd50, 1'b0,
                      9'd50, 1'b0, 8'd100, 40'h8000000000, 8'd100, 1'b0);

        // Reset state
        @(negedge clk); #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_out", {out_valid, out_sign, out_id, out_exp, out_frac}, 64'd0);
        chk("rst_dp", {dp_sign_diff, dp_diff_abs, dp_exp_f, dp_elarge_op}, 64'd0);
        chk("rst_dp_small", 64'(dp_esmall_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single transactions
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_vec(vecs[i].id, vecs[i]);
            req_valid = 2'(1 << vecs[i].id);
            out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(1 << vecs[i].id));
            @(posedge clk); #1;
            req_valid = 2'b00;
            chk($sformatf("vec%0d_dp", i), {dp_diff_abs, dp_sign_diff, dp_exp_f},
                {vecs[i].ediff, vecs[i].esd, vecs[i].eexpf});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out", i), {out_valid, out_id, out_sign, out_exp, out_frac},
                {1'b1, 1'(vecs[i].id), vecs[i].esign, vecs[i].eexp, vecs[i].efrac});
        end

        // Contention: alternate grants, outputs follow two cycles later
        do_reset();
        set_vec(0, vecs[0]);
        set_vec(1, vecs[1]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = (k < 6) ? 2'b11 : 2'b00;
            out_ready = 1'b1;
            #1;
            if (k < 6) chk($sformatf("cont_grant%0d", k), 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
            if (k >= 2)
                chk($sformatf("cont_out%0d", k), {out_valid, out_id, out_frac},
                    {1'b1, 1'((k - 2) % 2), ((k % 2) ? vecs[1].efrac : vecs[0].efrac)});
        end

        // Backpressure: two accepts then stall with stable outputs, then drain
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            req_valid = (k < 4) ? 2'b11 : 2'b00;
            out_ready = (k >= 4);
            #1;
            if (k < 4) chk($sformatf("bp_ready%0d", k), 64'(req_ready),
                           (k == 0) ? 64'd1 : (k == 1) ? 64'd2 : 64'd0);
            if (k == 2) held_frac = out_frac;
            if (k == 3) chk("bp_stable", {out_valid, out_id, out_frac}, {1'b1, 1'b0, held_frac});
            if (k == 4) chk("bp_drain0", {out_valid, out_id, out_exp, out_frac},
                            {1'b1, 1'b0, vecs[0].eexp, vecs[0].efrac});
            if (k == 5) chk("bp_drain1", {out_valid, out_id, out_exp, out_frac},
                            {1'b1, 1'b1, vecs[1].eexp, vecs[1].efrac});
            if (k == 6) chk("bp_drain_end", 64'(out_valid), 64'd0);
        end

        // Reset with S1 and S2 both full
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 2'b11;
            out_ready = 1'b0;
        end
        #3;
        chk("mid_full", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {out_valid, out_id, out_exp, out_frac}, 64'd0);
        chk("mid_rst_dp", {dp_diff_abs, dp_exp_f, dp_elarge_op}, 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        req_valid = 2'b00;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("mid_no_stale%0d", k), 64'(out_valid), 64'd0);
        end

        // Randomized traffic against the transaction-level model
        do_reset();
        q.delete();
        m_last = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            rand_ops(0);
            rand_ops(1);
            #1;
            egrant = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
            erdy   = ((req_valid != 2'b00) && (q.size() < 2 || out_ready)) ? egrant : 2'b00;
            chk("rand_ready", 64'(req_ready), 64'(erdy));
            if (q.size() == 2) chk("rand_full_valid", 64'(out_valid), 64'd1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rand_spurious_out", 64'(out_valid), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("rand_result", {out_id, out_sign, out_exp, out_frac}, 64'(e));
                end
            end
            if (erdy != 2'b00) begin
                int id;
                id = erdy[1] ? 1 : 0;
                q.push_back({erdy[1],
                             ref_add(req_a_frac[id*FW +: FW], req_a_exp[id*EW +: EW], req_a_sign[id],
                                     req_b_frac[id*FW +: FW], req_b_exp[id*EW +: EW], req_b_sign[id])});
                m_last = erdy[1];
            end
        end
        n_out = 0;
        while (q.size() != 0 && n_out < 10) begin
            @(negedge clk);
            req_valid = 2'b00;
            out_ready = 1'b1;
            #1;
            n_out++;
            if (out_valid) begin
                e = q.pop_front();
                chk("rand_drain", {out_id, out_sign, out_exp, out_frac}, 64'(e));
            end
        end
        chk("rand_drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fadd_far_sched.md
# fadd_far_sched

Two-requester scheduler for the shared 40-bit far-path floating-point adder in the fsincos datapath. It arbitrates between the sine and cosine pipelines and sorts each accepted operand pair by magnitude. It computes the alignment controls and drives the combinational far-path adder from a registered issue stage. The adder result is captured into an output register tagged with the requester ID, under valid/ready backpressure.

## Interface
- FRAC_WIDTH, 40: mantissa width incl. explicit leading 1
- EXP_WIDTH, 8: exponent width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  2  request valid, bit i = requester i (0 = sin, 1 = cos)
- req_ready  out  2  request accepted when valid & ready at clk edge
- req_a_frac, req_b_frac  in  2×FRAC_WIDTH  operand mantissas, packed [i*FRAC_WIDTH +: FRAC_WIDTH]
- req_a_exp, req_b_exp  in  2×EXP_WIDTH  operand exponents, packed likewise
- req_a_sign, req_b_sign  in  2  operand signs
- dp_esmall_op, dp_elarge_op  out  FRAC_WIDTH  to adder, smaller/larger-magnitude mantissa
- dp_exp_f  out  EXP_WIDTH  larger exponent
- dp_diff_abs  out  EXP_WIDTH+1  |exp_a − exp_b|
- dp_sign_diff  out  1  a_sign ^ b_sign
- dp_far_result  in  FRAC_WIDTH  adder normalized mantissa (combinational from dp_*)
- dp_exp_far  in  EXP_WIDTH  adder result exponent
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_frac  out  FRAC_WIDTH  result mantissa
- out_exp  out  EXP_WIDTH  result exponent
- out_sign  out  1  result sign
- out_id  out  1  requester that issued this result

## Operation
- Stage S1 (issue register): s1_valid, sorted operands, s1_sign, s1_id. Stage S2 (output register): out_*.
- s2_free = ~out_valid | out_ready. s1_free = ~s1_valid | s2_free.
- Arbitration: grant to a valid requester. If both are valid, grant the requester ≠ rr_last. req_ready[i] = grant[i] & s1_free. Only one bit of req_ready is ever set.
- rr_last updates to the granted ID only on an accepted transfer.
- Sort: a is large iff exp_a > exp_b, or exp_a == exp_b and frac_a ≥ frac_b. Otherwise b is large. Ties go to a.
- diff_abs = zero-extended exp_large − exp_small, width EXP_WIDTH+1.
- s1_sign = sign of the large operand. exp_f = exp_large.
- dp_* are driven directly from S1 registers.
- S1 → S2: when s1_valid & s2_free, the block captures dp_far_result, dp_exp_far, s1_sign and s1_id into out_* and sets out_valid. Otherwise out_* hold.
- S1 is loaded on accept. s1_valid clears when S1 advances with no new accept.
- A full-cancellation result from the adder is passed through unmodified. Near-path routing is upstream's responsibility.

## Timing
- Reset: req_ready=0, out_valid=0, out_frac=0, out_exp=0, out_sign=0, out_id=0, s1_valid=0, all dp_*=0, rr_last=1 (requester 0 wins the first contention).
- Latency: accept at edge N → out_valid high after edge N+1. Throughput is 1 result/cycle while out_ready=1.
- Stall: when out_valid & ~out_ready, out_* hold. If S1 is also full, req_ready=0.
- A requester's valid drop before acceptance is legal. Its data is don't-care when valid=0.
- If reset asserts mid-flight, all in-flight S1/S2 contents are discarded immediately, with no partial outputs.
- Accept, S1→S2 and out-handshake in the same cycle are all honoured: the pipeline shifts with no bubble.

## Configuration
- FADD_FAR_SCHED_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins contention, and rr_last is unused.
- Undefined (default): round-robin as specified above.

## Test plan
- Single add: req0 a={0x8000000000, exp 10, +}, b={0x8000000000, exp 9, +}. Required: dp_diff_abs=1, dp_sign_diff=0, and 2 cycles later out={0xC000000000, exp 10, +, id 0}.
- Carry-out: req1 a=b={0x8000000000, exp 10, +}. Required: out={0x8000000000, exp 11, +, id 1}.
- Subtract with left normalize: a={0x8000000000, exp 9, +}, b={0x8000000000, exp 10, −}. Required: b is sorted large, dp_sign_diff=1, out={0x8000000000, exp 9, −}.
- Contention: both requesters held valid for 6 cycles with out_ready=1. Required: grants alternate 0,1,0,1,0,1 and out_id follows the same order.
- Backpressure: out_ready=0 for 4 cycles with both requesters valid. Required: exactly 2 transactions accepted, then req_ready=0 and out_* stable. On release, results drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with S1 and S2 full. Required: out_valid=0 immediately, and no stale result after reset deasserts.
